ext_mem_responder: RTL and testbench
====================================

# ext_mem_responder

Synthesizable two-channel external byte memory that sits directly downstream of the HLS-generated `main` accelerator's `Mout_*` master bus. It answers every channel's read or write to its address window with programmable latency, and raises per-channel `M_DataRdy` exactly as the accelerator's memory handshake expects. A load port fills or dumps the array while the accelerator is idle, so the same block can serve FPGA bring-up and simulation.

## Interface
Parameters:
- `BASE_ADDR`, 0: first byte address of the window.
- `MEMSIZE`, 256: number of bytes in the window (≥1).
- `ADDR_W`, 12: per-channel address width.
- `READ_DELAY`, 2: read latency in cycles (≥2).
- `WRITE_DELAY`, 1: write latency in cycles (≥1).

Ports:
- `clock`  in  1: single clock; all logic acts on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `Mout_oe_ram`  in  2: per-channel read enable.
- `Mout_we_ram`  in  2: per-channel write enable.
- `Mout_addr_ram`  in  2*ADDR_W: channel 0 uses `[ADDR_W-1:0]`; channel 1 uses the upper field.
- `Mout_Wdata_ram`  in  16: write data, channel c on `[8c+7:8c]`.
- `Mout_data_ram_size`  in  8: access size in bits, channel c on `[4c+3:4c]`.
- `M_Rdata_ram`  out  16: read data, channel c on `[8c+7:8c]`.
- `M_DataRdy`  out  2: per-channel access complete.
- `ld_en`  in  1: load-port access strobe.
- `ld_we`  in  1: 1 = write the array, 0 = read it.
- `ld_addr`  in  ADDR_W: load address (absolute).
- `ld_wdata`  in  8: load write byte.
- `ld_rdata`  out  8: load read byte, registered.
- `err`  out  1: sticky protocol error.

## Operation
- A channel hits when `BASE_ADDR ≤ addr < BASE_ADDR+MEMSIZE`. The array index is `addr − BASE_ADDR`. A miss is ignored: no write, rdata 0, `M_DataRdy`=0 for that channel.
- Write mask: `mask = (1<<size)−1`, truncated to 8 bits, so size ≥ 8 gives `8'hFF`. Stored byte = `(wdata & mask) | (old & ~mask)`.
- Each channel has a latency counter `cnt_c`, reset value 0:
  - On a hit read: `cnt_c` increments while `cnt_c < READ_DELAY−1`; otherwise it returns to 0.
  - On a hit write: the same rule applies with `WRITE_DELAY−1`.
  - With no hit: `cnt_c` clears to 0.
- `M_DataRdy[c]` (combinational) = hit AND ((oe AND `cnt_c == READ_DELAY−1`) OR (we AND `cnt_c == WRITE_DELAY−1`)).
- Read data passes through a `READ_DELAY−1`-stage register pipeline per channel, sampling the array at the current address every cycle. `M_Rdata_ram` is the pipeline output, valid while `M_DataRdy[c]`=1.
- The master holds oe/we, addr, wdata and size stable until it sees `M_DataRdy`.
- A write commits on the rising edge that ends the cycle in which `M_DataRdy[c]`=1.
- If both channels commit to the same byte on the same edge, channel 1 wins.
- `err` sets and holds when:
  - `oe[c]` and `we[c]` are both 1 on the same edge, either channel; or
  - `ld_en` is 1 while any oe/we bit is 1.

  In both cases, the offending accesses of that cycle are dropped. Only `reset` clears `err`.
- Load port:
  - `ld_en & ld_we` writes the full byte at the next edge.
  - `ld_en & ~ld_we` puts the byte on `ld_rdata` after one edge.
  - Out-of-window load addresses are ignored; a read of one returns 0.
- Array contents are not cleared by `reset`.

## Timing
- Reset values: `M_Rdata_ram`=0, pipeline registers 0, `M_DataRdy`=0, `cnt_c`=0, `ld_rdata`=0, `err`=0.
- Read with `READ_DELAY`=2: oe and address valid in cycle t; `M_DataRdy` and data valid in cycle t+1; `cnt_c` back to 0 at t+2. With latency L, data is valid in cycle t+L−1.
- Write with `WRITE_DELAY`=1: `M_DataRdy` is high in the same cycle as we; the byte is stored at that cycle's closing edge.
- Back-to-back accesses:
  - A master that keeps oe high after `DataRdy` begins a new access.
  - `cnt_c` wraps to 0, so `DataRdy` repeats every `READ_DELAY` cycles.
- Channels are fully independent and may complete in the same cycle.
- `reset` asserted mid-access: the counter, pipeline and `DataRdy` clear at that edge. A write whose `DataRdy` cycle coincides with reset still commits.
- The address changing mid-access is not legal, but the behaviour is defined: the counter keeps counting, and the data reflects the address sampled `READ_DELAY−1` cycles earlier.

## Test plan
- Setup for all scenarios: `BASE_ADDR`=256, `MEMSIZE`=256.
- Load and read back: load writes 8'hA5 at address 300, then load-reads 300 → `ld_rdata`=8'hA5 one cycle later.
- Channel-0 read: 8'h3C is loaded at 260; oe0 with addr 260 held from cycle t → `M_DataRdy`=2'b01 and `M_Rdata_ram[7:0]`=8'h3C at t+1, `DataRdy` 0 at t+2 after oe drops.
- Masked write: mem[270]=8'hFF; channel 1 writes 8'h05 with size 4 → readback 8'hF5. The same write with size 8 → readback 8'h05.
- Out of window: oe0 at address 100 held for 5 cycles → `M_DataRdy` stays 0 and rdata stays 0. The same access with `READ_DELAY`=3 at address 260 → `DataRdy` first seen at t+2.
- Collision: both channels write address 280 in the same cycle (ch0 8'h11, ch1 8'h22) → mem[280]=8'h22, and both `DataRdy` bits are high that cycle.
- Error and reset: oe0 and we0 both high → `err`=1, persists, and no write occurs. `reset` asserted mid-read → `M_DataRdy`=0 the next cycle, `err`=0, and loaded contents are still readable.

Source files
------------

// File: rtl/ext_mem_responder_if.sv
// ext_mem_responder_if: Mout_* master bus between the accelerator and the external memory
interface ext_mem_responder_if #(
  parameter int ADDR_W = 12
);
  logic [1:0]          Mout_oe_ram;
  logic [1:0]          Mout_we_ram;
  logic [2*ADDR_W-1:0] Mout_addr_ram;
  logic [15:0]         Mout_Wdata_ram;
  logic [7:0]          Mout_data_ram_size;
  logic [15:0]         M_Rdata_ram;
  logic [1:0]          M_DataRdy;
  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  M_Rdata_ram, M_DataRdy
  );
  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output M_Rdata_ram, M_DataRdy
  );
endinterface

// File: rtl/ext_mem_responder.sv
// ext_mem_responder: two-channel byte memory with programmable latency, masked writes and a load port
module ext_mem_responder #(
  parameter int BASE_ADDR   = 0,
  parameter int MEMSIZE     = 256,
  parameter int ADDR_W      = 12,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic              clock,
  input  logic              reset,
  ext_mem_responder_if.slave bus,
  input  logic              ld_en,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  output logic [7:0]        ld_rdata,
  output logic              err
);
  localparam int IW = MEMSIZE > 1 ? $clog2(MEMSIZE) : 1;
  localparam int MAXD = READ_DELAY > WRITE_DELAY ? READ_DELAY : WRITE_DELAY;
  localparam int CW = $clog2(MAXD) + 1;
  localparam int P = READ_DELAY - 1;
  localparam logic [CW-1:0] R_LAST = CW'(READ_DELAY - 1);
  localparam logic [CW-1:0] W_LAST = CW'(WRITE_DELAY - 1);
  localparam logic [31:0] LO = 32'(BASE_ADDR);
  localparam logic [31:0] SZ = 32'(MEMSIZE);
  logic [7:0]    r_mem [MEMSIZE];
  logic [CW-1:0] r_cnt [2];
  logic [7:0]    r_pipe [2][P];
  logic [1:0]    w_hit, w_oe, w_we, w_rdy;
  logic [IW-1:0] w_idx [2];
  logic [7:0]    w_mask [2];
  logic [7:0]    w_wdata [2];
  logic [7:0]    w_rd [2];
  logic [ADDR_W-1:0] w_addr [2];
  logic [3:0]    w_sz [2];
  logic          w_conflict, w_err, w_ld_hit;
  logic [IW-1:0] w_ld_idx;
  function automatic logic in_win(input logic [ADDR_W-1:0] a);
    return (32'(a) - LO) < SZ;
  endfunction
  function automatic logic [IW-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return IW'(32'(a) - LO);
  endfunction
  always_comb begin
    w_conflict = ld_en & |(bus.Mout_oe_ram | bus.Mout_we_ram);
    w_err = w_conflict | |(bus.Mout_oe_ram & bus.Mout_we_ram);
    w_ld_hit = in_win(ld_addr);
    w_ld_idx = to_idx(ld_addr);
    for (int c = 0; c < 2; c++) begin
      w_addr[c] = bus.Mout_addr_ram[c*ADDR_W +: ADDR_W];
      w_sz[c] = bus.Mout_data_ram_size[4*c +: 4];
      w_wdata[c] = bus.Mout_Wdata_ram[8*c +: 8];
      w_hit[c] = in_win(w_addr[c]);
      w_idx[c] = to_idx(w_addr[c]);
      w_oe[c] = bus.Mout_oe_ram[c] & ~bus.Mout_we_ram[c] & ~ld_en & w_hit[c];
      w_we[c] = bus.Mout_we_ram[c] & ~bus.Mout_oe_ram[c] & ~ld_en & w_hit[c];
      w_rdy[c] = (w_oe[c] & (r_cnt[c] == R_LAST)) | (w_we[c] & (r_cnt[c] == W_LAST));
      w_mask[c] = w_sz[c] >= 4'd8 ? 8'hFF : 8'((9'd1 << w_sz[c]) - 9'd1);
      w_rd[c] = w_hit[c] ? r_mem[w_idx[c]] : 8'h00;
    end
  end
  assign bus.M_DataRdy = w_rdy;
  assign bus.M_Rdata_ram = {r_pipe[1][P-1], r_pipe[0][P-1]};
  always_ff @(posedge clock) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) r_cnt[c] <= '0;
      else if (w_oe[c]) r_cnt[c] <= r_cnt[c] < R_LAST ? r_cnt[c] + 1'b1 : '0;
      else if (w_we[c]) r_cnt[c] <= r_cnt[c] < W_LAST ? r_cnt[c] + 1'b1 : '0;
      else r_cnt[c] <= '0;
    end
  end
  always_ff @(posedge clock) begin
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < P; s++) begin
        if (reset) r_pipe[c][s] <= 8'h00;
        else r_pipe[c][s] <= s == 0 ? w_rd[c] : r_pipe[c][s == 0 ? 0 : s-1];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (ld_en & ld_we & ~w_conflict & w_ld_hit) r_mem[w_ld_idx] <= ld_wdata;
    for (int c = 0; c < 2; c++) begin
      if (w_rdy[c] & w_we[c]) r_mem[w_idx[c]] <= (w_wdata[c] & w_mask[c]) | (r_mem[w_idx[c]] & ~w_mask[c]);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ld_rdata <= 8'h00;
      err <= 1'b0;
    end else begin
      err <= err | w_err;
      if (ld_en & ~ld_we & ~w_conflict) ld_rdata <= w_ld_hit ? r_mem[w_ld_idx] : 8'h00;
    end
  end
endmodule

// File: tb/tb_ext_mem_responder.sv
// tb_ext_mem_responder: table-driven cycle trace plus reset, load-conflict and long-latency sequences
module tb_ext_mem_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  ext_mem_responder_if #(.ADDR_W(12)) bus ();
  ext_mem_responder_if #(.ADDR_W(12)) bus3 ();
  logic ld_en, ld_we, ld_en3, ld_we3;
  logic [11:0] ld_addr, ld_addr3;
  logic [7:0] ld_wdata, ld_rdata, ld_wdata3, ld_rdata3;
  logic err, err3;
  ext_mem_responder #(.BASE_ADDR(256), .MEMSIZE(256), .ADDR_W(12), .READ_DELAY(2), .WRITE_DELAY(1)) u_dut (
    .clock(clock), .reset(reset), .bus(bus.slave), .ld_en(ld_en), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .err(err)
  );
  ext_mem_responder #(.BASE_ADDR(256), .MEMSIZE(256), .ADDR_W(12), .READ_DELAY(3), .WRITE_DELAY(1)) u_dut3 (
    .clock(clock), .reset(reset), .bus(bus3.slave), .ld_en(ld_en3), .ld_we(ld_we3),
    .ld_addr(ld_addr3), .ld_wdata(ld_wdata3), .ld_rdata(ld_rdata3), .err(err3)
  );
  typedef struct {
    logic [1:0]  ld;
    logic [11:0] la;
    logic [7:0]  lw;
    logic [1:0]  oe, we;
    logic [11:0] a0, a1;
    logic [15:0] wd;
    logic [7:0]  sz;
    logic [1:0]  e_rdy;
    logic [15:0] e_rd;
    logic [7:0]  e_ldr;
    logic        e_err;
  } vec_t;
  vec_t v[$];
  int total = 0;
  int bad = 0;
  function automatic vec_t mk(logic [1:0] ld, logic [11:0] la, logic [7:0] lw, logic [1:0] oe, logic [1:0] we,
                              logic [11:0] a0, logic [11:0] a1, logic [15:0] wd, logic [7:0] sz,
                              logic [1:0] e_rdy, logic [15:0] e_rd, logic [7:0] e_ldr, logic e_err);
    vec_t t;
    t.ld = ld; t.la = la; t.lw = lw; t.oe = oe; t.we = we; t.a0 = a0; t.a1 = a1; t.wd = wd; t.sz = sz;
    t.e_rdy = e_rdy; t.e_rd = e_rd; t.e_ldr = e_ldr; t.e_err = e_err;
    return t;
  endfunction
  task automatic chk(string n, logic [15:0] a, logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  task automatic set_in(logic [1:0] ld, logic [11:0] la, logic [7:0] lw, logic [1:0] oe, logic [1:0] we,
                        logic [11:0] a0, logic [11:0] a1, logic [15:0] wd, logic [7:0] sz);
    ld_en = ld[1]; ld_we = ld[0]; ld_addr = la; ld_wdata = lw;
    bus.Mout_oe_ram = oe; bus.Mout_we_ram = we; bus.Mout_addr_ram = {a1, a0};
    bus.Mout_Wdata_ram = wd; bus.Mout_data_ram_size = sz;
  endtask
  task automatic set_in3(logic [1:0] ld, logic [11:0] la, logic [7:0] lw, logic [1:0] oe, logic [11:0] a0);
    ld_en3 = ld[1]; ld_we3 = ld[0]; ld_addr3 = la; ld_wdata3 = lw;
    bus3.Mout_oe_ram = oe; bus3.Mout_we_ram = 2'b00; bus3.Mout_addr_ram = {12'd0, a0};
    bus3.Mout_Wdata_ram = 16'h0; bus3.Mout_data_ram_size = 8'h0;
  endtask
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask
  initial begin
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
    v.push_back(mk(3, 300, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
    v.push_back(mk(2, 300, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
    v.push_back(mk(3, 260, 8'h3C, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'hA5, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'hA5, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 260, 0, 0, 0, 0, 16'h0000, 8'hA5, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 260, 0, 0, 0, 1, 16'h003C, 8'hA5, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h003C, 8'hA5, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'hA5, 0));
    v.push_back(mk(3, 270, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'hA5, 0));
    v.push_back(mk(0, 0, 0, 0, 2, 0, 270, 16'h0500, 8'h40, 2, 16'h0000, 8'hA5, 0));
    v.push_back(mk(0, 0, 0, 2, 0, 0, 270, 0, 0, 0, 16'hFF00, 8'hA5, 0));
    v.push_back(mk(0, 0, 0, 2, 0, 0, 270, 0, 0, 2, 16'hF500, 8'hA5, 0));
    v.push_back(mk(0, 0, 0, 0, 2, 0, 270, 16'h0500, 8'h80, 2, 16'hF500, 8'hA5, 0));
    v.push_back(mk(2, 270, 0, 0, 0, 0, 0, 0, 0, 0, 16'hF500, 8'hA5, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h05, 0));
    for (int i = 0; i < 5; i++) v.push_back(mk(0, 0, 0, 1, 0, 100, 0, 0, 0, 0, 16'h0000, 8'h05, 0));
    v.push_back(mk(3, 280, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h05, 0));
    v.push_back(mk(0, 0, 0, 0, 3, 280, 280, 16'h2211, 8'h88, 3, 16'h0000, 8'h05, 0));
    v.push_back(mk(2, 280, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h05, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h22, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 260, 0, 0, 0, 0, 16'h0000, 8'h22, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 260, 0, 0, 0, 1, 16'h003C, 8'h22, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 260, 0, 0, 0, 0, 16'h003C, 8'h22, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 260, 0, 0, 0, 1, 16'h003C, 8'h22, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h003C, 8'h22, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h22, 0));
    v.push_back(mk(0, 0, 0, 1, 1, 270, 0, 16'h0077, 8'h08, 0, 16'h0000, 8'h22, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0005, 8'h22, 1));
    v.push_back(mk(2, 270, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h22, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h05, 1));
    v.push_back(mk(3, 270, 8'hEE, 2, 0, 0, 260, 0, 0, 0, 16'h0000, 8'h05, 1));
    v.push_back(mk(2, 270, 0, 0, 0, 0, 0, 0, 0, 0, 16'h3C00, 8'h05, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h05, 1));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_in3(0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_rdy", 16'(bus.M_DataRdy), 16'h0);
    chk("rst_rd", bus.M_Rdata_ram, 16'h0);
    chk("rst_ldr", 16'(ld_rdata), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    next_cycle();
    reset = 1'b0;
    foreach (v[i]) begin
      set_in(v[i].ld, v[i].la, v[i].lw, v[i].oe, v[i].we, v[i].a0, v[i].a1, v[i].wd, v[i].sz);
      @(negedge clock);
      chk($sformatf("v%0d_rdy", i), 16'(bus.M_DataRdy), 16'(v[i].e_rdy));
      chk($sformatf("v%0d_rd", i), bus.M_Rdata_ram, v[i].e_rd);
      chk($sformatf("v%0d_ldr", i), 16'(ld_rdata), 16'(v[i].e_ldr));
      chk($sformatf("v%0d_err", i), 16'(err), 16'(v[i].e_err));
      next_cycle();
    end
    set_in(0, 0, 0, 1, 0, 260, 0, 0, 0);
    @(negedge clock);
    chk("mid_rst_t0_rdy", 16'(bus.M_DataRdy), 16'h0);
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_t1_rdy", 16'(bus.M_DataRdy), 16'h1);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_rdy", 16'(bus.M_DataRdy), 16'h0);
    chk("post_rst_err", 16'(err), 16'h0);
    chk("post_rst_rd", bus.M_Rdata_ram, 16'h0);
    next_cycle();
    @(negedge clock);
    chk("post_rst_rdy2", 16'(bus.M_DataRdy), 16'h1);
    chk("post_rst_rd2", bus.M_Rdata_ram, 16'h003C);
    next_cycle();
    set_in(2, 300, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("post_rst_ldr", 16'(ld_rdata), 16'h00A5);
    next_cycle();
    set_in(3, 300, 8'h00, 1, 0, 260, 0, 0, 0);
    @(negedge clock);
    chk("ldc_rdy", 16'(bus.M_DataRdy), 16'h0);
    chk("ldc_err_pre", 16'(err), 16'h0);
    next_cycle();
    set_in(2, 300, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("ldc_err", 16'(err), 16'h1);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("ldc_dropped", 16'(ld_rdata), 16'h00A5);
    next_cycle();
    set_in3(3, 260, 8'h3C, 0, 0);
    next_cycle();
    set_in3(0, 0, 0, 1, 260);
    @(negedge clock);
    chk("rd3_t0_rdy", 16'(bus3.M_DataRdy), 16'h0);
    next_cycle();
    @(negedge clock);
    chk("rd3_t1_rdy", 16'(bus3.M_DataRdy), 16'h0);
    next_cycle();
    @(negedge clock);
    chk("rd3_t2_rdy", 16'(bus3.M_DataRdy), 16'h1);
    chk("rd3_t2_rd", bus3.M_Rdata_ram, 16'h003C);
    next_cycle();
    set_in3(0, 0, 0, 0, 0);
    @(negedge clock);
    chk("rd3_t3_rdy", 16'(bus3.M_DataRdy), 16'h0);
    chk("rd3_err", 16'(err3), 16'h0);
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
